// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the MIPS RAW-hazard / control-flush scoreboard.
// Shadow entries are sized by HZ_REG_AW. The top's REG_AW parameter must equal HZ_REG_AW.
package mips_hazard_pkg;

    localparam int HZ_REG_AW = 5;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    localparam logic [HZ_REG_AW-1:0] ZERO_REG = '0;

    // Shadow stage indices, counted from the stage after ID.
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                 v;    // slot holds a live instruction
        logic [HZ_REG_AW-1:0] dst;  // destination register
        logic                 rw;   // writes dst
        logic                 mr;   // is a load
    } hz_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard request and pipeline-control response bundle.
// master = ID/pipeline side, slave = hazard_scoreboard.
interface hazard_scoreboard_if
    import mips_hazard_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dst;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_jump;
    logic              mem_pcsrc;
    logic              stall;
    logic              bubble;
    logic              jump_take;
    logic              flush_ifid;
    logic              flush_ex;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_regwrite, id_memread, id_jump, mem_pcsrc,
        input  stall, bubble, jump_take, flush_ifid, flush_ex
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_regwrite, id_memread, id_jump, mem_pcsrc,
        output stall, bubble, jump_take, flush_ifid, flush_ex
    );
endinterface

// File: rtl/hazard_shadow_pipe.sv
// DEPTH-entry shift register of in-flight destinations (EX onward).
// Entry 0 takes the issuing ID instruction. A bubble is presented as ins.v = 0.
// kill[k] invalidates whatever moves into entry k this cycle.
module hazard_shadow_pipe
    import mips_hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  hz_entry_t             ins,
    input  logic      [DEPTH-1:0] kill,
    output hz_entry_t [DEPTH-1:0] ent
);

    // Advance one stage per cycle. The oldest entry falls off the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent <= '0;
        end else begin
            ent[0]   <= ins;
            ent[0].v <= ins.v & ~kill[0];
            for (int k = 1; k < DEPTH; k++) begin
                ent[k]   <= ent[k-1];
                ent[k].v <= ent[k-1].v & ~kill[k];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW-hazard stall and control-flush unit for the in-order MIPS pipeline.
// Optional feature macro: HAZ_FORWARDING_EN.
//   Defined:   only loads younger than LOAD_LAT stages stall. ALU results are bypassed.
//   Undefined: any writer still ahead of the write-before-read stage stalls.
// All outputs are combinational. The shadow pipe is the only state.
module hazard_scoreboard
    import mips_hazard_pkg::*;
#(
    parameter int REG_AW   = HZ_REG_AW,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave hz
);

    hz_entry_t [DEPTH-1:0] shadow;
    hz_entry_t             ins;
    logic      [DEPTH-1:0] kill;
    logic      [DEPTH-1:0] win;
    logic      [DEPTH-1:0] hit_rs;
    logic      [DEPTH-1:0] hit_rt;
    logic                  haz;
    logic                  stall;
    logic                  bubble;
    logic                  jump_take;
    logic                  flush_ifid;
    logic                  flush_ex;
    logic                  unused_shadow;

    // Per-stage hazard window and source compares.
    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
`ifdef HAZ_FORWARDING_EN
        if (k < LOAD_LAT) begin : g_win
            assign win[k] = shadow[k].mr;
        end else begin : g_nowin
            assign win[k] = 1'b0;
        end
`else
        if (k < DEPTH - 1) begin : g_win
            assign win[k] = 1'b1;
        end else begin : g_nowin
            assign win[k] = 1'b0;
        end
`endif
        assign hit_rs[k] = shadow[k].v & shadow[k].rw & win[k]
                         & (shadow[k].dst == hz.id_rs) & (hz.id_rs != ZERO_REG);
        assign hit_rt[k] = shadow[k].v & shadow[k].rw & win[k]
                         & (shadow[k].dst == hz.id_rt) & (hz.id_rt != ZERO_REG);
    end

    assign haz = hz.id_valid & ((hz.id_use_rs & (|hit_rs)) | (hz.id_use_rt & (|hit_rt)));

    // Some entry fields feed no compare in some builds, for example WB and the mr bits.
    assign unused_shadow = ^shadow;

    // Priority decode: taken branch beats hazard, and hazard beats jump. Reset silences everything.
    always_comb begin
        stall      = 1'b0;
        bubble     = 1'b0;
        jump_take  = 1'b0;
        flush_ifid = 1'b0;
        flush_ex   = 1'b0;
        if (!reset) begin
            if (hz.mem_pcsrc) begin
                flush_ifid = 1'b1;
                bubble     = 1'b1;
                flush_ex   = 1'b1;
            end else if (haz) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end else if (hz.id_jump && hz.id_valid) begin
                jump_take  = 1'b1;
                flush_ifid = 1'b1;
            end
        end
    end

    // Only the instruction leaving EX is killed by a taken branch in MEM.
    always_comb begin
        kill          = '0;
        kill[STG_MEM] = flush_ex;
    end

    assign ins.v   = hz.id_valid & ~bubble;
    assign ins.dst = hz.id_dst;
    assign ins.rw  = hz.id_regwrite;
    assign ins.mr  = hz.id_memread;

    hazard_shadow_pipe #(.DEPTH(DEPTH)) u_pipe (
        .clk   (clk),
        .reset (reset),
        .ins   (ins),
        .kill  (kill),
        .ent   (shadow)
    );

    assign hz.stall      = stall;
    assign hz.bubble     = bubble;
    assign hz.jump_take  = jump_take;
    assign hz.flush_ifid = flush_ifid;
    assign hz.flush_ex   = flush_ex;

endmodule
